input_loader: RTL

- Write side of the pixel/weight interface consumed by the first convolution layer.
- During s_LOAD, accepts a byte stream from the chip input pins and assembles the 28x28 binary image plus the 72-bit weight vector into registers.
- Drives those registers as static buffers to the layer logic and raises load_done when the full frame is present.
- Sits between the top-level pin interface and the layer-one block; the top-level FSM moves s_LOAD to s_LAYER_1 on load_done.

---
 rtl/bnn_pkg.sv | 19 +
 rtl/input_loader.sv | 87 ++++++++
 2 files changed

// File: rtl/bnn_pkg.sv
// Shared BNN definitions: top-level FSM states, image/kernel geometry and loader frame sizing.
package bnn_pkg;

  typedef enum logic [2:0] {
    s_IDLE,
    s_LOAD,
    s_LAYER_1,
    s_LAYER_2,
    s_LAYER_3
  } state_t;

  localparam int IMG_DIM     = 28;
  localparam int KERNEL_DIM  = 3;
  localparam int PIX_BYTES   = IMG_DIM * IMG_DIM / 8;
  localparam int WGT_BYTES   = KERNEL_DIM * KERNEL_DIM;
  localparam int FRAME_BYTES = PIX_BYTES + WGT_BYTES;
  localparam int CNT_W       = 7;

endpackage

// File: rtl/input_loader.sv
// Assembles a byte stream into the static image/weight buffers for layer one; a byte
// accepted at edge N is visible after edge N; ready is high only in L_PIX/L_WGT, other bytes are dropped.
module input_loader
  import bnn_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         rst,
  input  state_t                                       state,
  input  logic [7:0]                                   data_in,
  input  logic                                         data_valid,
  output logic                                         ready,
  output logic [IMG_DIM-1:0][IMG_DIM-1:0]              pixels,
  output logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][7:0]   weights,
  output logic [CNT_W-1:0]                             byte_cnt,
  output logic                                         load_done
);

  typedef enum logic [1:0] {
    L_IDLE,
    L_PIX,
    L_WGT,
    L_DONE
  } load_st_t;

  load_st_t                   ls, ls_nxt;
  logic [PIX_BYTES*8-1:0]     pix_q;
  logic [WGT_BYTES*8-1:0]     wgt_q;
  logic                       accept;
  logic                       start;
  logic                       pix_we, wgt_we;
  logic                       pix_last, wgt_last;
  logic [9:0]                 pix_base;
  logic [6:0]                 wgt_base;

  assign ready   = (ls == L_PIX) || (ls == L_WGT);
  assign accept  = data_valid && ready;
  assign pixels  = pix_q;
  assign weights = wgt_q;

  // Row-major packed buffers: flat pixel f and weight j land at bit 8k+b and 8j directly.
  assign pix_base = {byte_cnt, 3'b000};
  assign wgt_base = 7'(byte_cnt - 7'(PIX_BYTES)) << 3;

  always_comb begin
    start    = (ls == L_IDLE) && (state == s_LOAD);
    pix_we   = accept && (ls == L_PIX);
    wgt_we   = accept && (ls == L_WGT);
    pix_last = pix_we && (byte_cnt == 7'(PIX_BYTES - 1));
    wgt_last = wgt_we && (byte_cnt == 7'(FRAME_BYTES - 1));
    ls_nxt   = ls;
    case (ls)
      L_IDLE: if (state == s_LOAD) ls_nxt = L_PIX;
      L_PIX: begin
        if (state != s_LOAD)  ls_nxt = L_IDLE;
        else if (pix_last)    ls_nxt = L_WGT;
      end
      // A final byte arriving in the abort cycle still completes the frame.
      L_WGT: begin
        if (wgt_last)              ls_nxt = L_DONE;
        else if (state != s_LOAD)  ls_nxt = L_IDLE;
      end
      L_DONE: if (state != s_LOAD) ls_nxt = L_IDLE;
      default: ls_nxt = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ls        <= L_IDLE;
      byte_cnt  <= '0;
      load_done <= 1'b0;
      pix_q     <= '0;
      wgt_q     <= '0;
    end else begin
      ls <= ls_nxt;
      if (start) begin
        byte_cnt  <= '0;
        load_done <= 1'b0;
      end
      if (pix_we || wgt_we) byte_cnt <= byte_cnt + 7'd1;
      if (pix_we) pix_q[pix_base +: 8] <= data_in;
      if (wgt_we) wgt_q[wgt_base +: 8] <= data_in;
      if (wgt_last) load_done <= 1'b1;
    end
  end

endmodule
